// File: rtl/evm_vote_session_ctrl.sv
// evm_vote_session_ctrl
// Runs one voting session per voter: ID entry, database lookup, already-voted
// check, single candidate press, then tally update. Also serves per-candidate
// counts and the total for result readout.
// Optional build macro: EVM_VOTE_TIMEOUT_EN adds a WAIT_VOTE timeout that
// rejects the session with code 11 after TIMEOUT_CYC cycles without a press.
module evm_vote_session_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int COUNT_W     = 8,
  parameter int DB_LAT      = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        id_valid,
  input  logic [4:0]                  voter_id,
  input  logic [NUM_CAND-1:0]         cand_btn,
  input  logic [$clog2(NUM_CAND)-1:0] result_sel,
  output logic                        db_read,
  output logic [4:0]                  db_voter_id,
  input  logic                        db_status,
  output logic                        busy,
  output logic                        vote_accepted,
  output logic                        vote_rejected,
  output logic [1:0]                  reject_code,
  output logic [COUNT_W-1:0]          result_count,
  output logic [COUNT_W-1:0]          total_votes
);

  localparam int SEL_W  = $clog2(NUM_CAND);
  localparam int WAIT_W = (DB_LAT < 1) ? 1 : $clog2(DB_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_WAIT_VOTE, S_CAST, S_REJECT
  } state_t;

  state_t               state, state_next;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 lookup_done;
  logic                 status_q;
  logic [SEL_W-1:0]     cand_idx;
  logic [SEL_W-1:0]     btn_idx;
  logic                 btn_valid;
  logic                 timeout_hit;
  logic                 cast_commit;
  logic [31:0]          voted;
  logic [COUNT_W-1:0]   count [NUM_CAND];

  assign lookup_done = (wait_cnt == WAIT_W'(DB_LAT));
  assign btn_valid   = $onehot(cand_btn);
  // A vote only lands if the session was not aborted by leaving voting mode.
  assign cast_commit = (state == S_CAST) && mode;
  assign busy        = (state != S_IDLE);

`ifdef EVM_VOTE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Cycles spent in WAIT_VOTE; restarts from zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     to_cnt <= '0;
    else if (state != S_WAIT_VOTE) to_cnt <= '0;
    else                           to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Index of the single pressed button (meaningful only when btn_valid).
  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_btn[i]) btn_idx = SEL_W'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; leaving voting mode aborts any session in progress.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:      if (mode && id_valid) state_next = S_LOOKUP;
      S_LOOKUP:    if (lookup_done) state_next = S_CHECK;
      S_CHECK:     state_next = (!status_q || voted[db_voter_id]) ? S_REJECT : S_WAIT_VOTE;
      S_WAIT_VOTE: begin
        if (btn_valid)        state_next = S_CAST;
        else if (timeout_hit) state_next = S_REJECT;
      end
      S_CAST:      state_next = S_IDLE;
      S_REJECT:    state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (state != S_IDLE && !mode) state_next = S_IDLE;
  end

  // Lookup sequencing: read enable, latency counter, registered DB answer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_read     <= 1'b0;
      db_voter_id <= '0;
      wait_cnt    <= '0;
      status_q    <= 1'b0;
    end else begin
      db_read <= (state_next == S_LOOKUP);
      if (state == S_IDLE && state_next == S_LOOKUP) db_voter_id <= voter_id;
      if (state == S_LOOKUP) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                   wait_cnt <= '0;
      if (state == S_LOOKUP && lookup_done) status_q <= db_status;
    end
  end

  // Session outcome: latched candidate, result pulses and reject reason.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_idx      <= '0;
      vote_accepted <= 1'b0;
      vote_rejected <= 1'b0;
      reject_code   <= 2'b00;
    end else begin
      vote_accepted <= cast_commit;
      vote_rejected <= (state == S_REJECT) && mode;
      if (state == S_WAIT_VOTE && btn_valid) cand_idx <= btn_idx;
      if (state == S_IDLE && state_next == S_LOOKUP)
        reject_code <= 2'b00;
      else if (state == S_CHECK && state_next == S_REJECT)
        reject_code <= status_q ? 2'b10 : 2'b01;
      else if (state == S_WAIT_VOTE && state_next == S_REJECT)
        reject_code <= 2'b11;
    end
  end

  // Tallies and voted bitmap; saturating counts, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the tally array is a handful of flops that must power up at
      // zero, so it is reset explicitly rather than left to a RAM macro.
      for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
      total_votes <= '0;
      voted       <= '0;
    end else if (cast_commit) begin
      if (count[cand_idx] != '1) count[cand_idx] <= count[cand_idx] + COUNT_W'(1);
      if (total_votes != '1)     total_votes     <= total_votes + COUNT_W'(1);
      voted[db_voter_id] <= 1'b1;
    end
  end

  // Readout mux; out-of-range selects read as zero.
  always_comb begin
    result_count = '0;
    if (!mode && (int'(result_sel) < NUM_CAND)) result_count = count[result_sel];
  end

endmodule

// File: tb/tb_evm_vote_session_ctrl.sv
// tb_evm_vote_session_ctrl
// Session-level bench: each voter session is driven as a transaction and its
// outcome (accept/reject/abort, reject code, pulse timing, tallies) is
// predicted from a voted[] table and per-candidate counts.
module tb_evm_vote_session_ctrl;

  localparam int NUM_CAND = 4;
  localparam int COUNT_W  = 8;
  localparam int DB_LAT   = 1;
  localparam int SEL_W    = $clog2(NUM_CAND);
  localparam int CNT_MAX  = (1 << COUNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                mode;
  logic                id_valid;
  logic [4:0]          voter_id;
  logic [NUM_CAND-1:0] cand_btn;
  logic [SEL_W-1:0]    result_sel;
  logic                db_read;
  logic [4:0]          db_voter_id;
  logic                db_status;
  logic                busy;
  logic                vote_accepted;
  logic                vote_rejected;
  logic [1:0]          reject_code;
  logic [COUNT_W-1:0]  result_count;
  logic [COUNT_W-1:0]  total_votes;

  evm_vote_session_ctrl #(
    .NUM_CAND(NUM_CAND), .COUNT_W(COUNT_W), .DB_LAT(DB_LAT), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .id_valid(id_valid),
    .voter_id(voter_id), .cand_btn(cand_btn), .result_sel(result_sel),
    .db_read(db_read), .db_voter_id(db_voter_id), .db_status(db_status),
    .busy(busy), .vote_accepted(vote_accepted), .vote_rejected(vote_rejected),
    .reject_code(reject_code), .result_count(result_count),
    .total_votes(total_votes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit voted_m [32];
  int count_m [NUM_CAND];
  int total_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) voted_m[i] = 1'b0;
    for (int c = 0; c < NUM_CAND; c++) count_m[c] = 0;
    total_m = 0;
  endtask

  // Zero or multi-hot button pattern; never a valid vote.
  function automatic logic [NUM_CAND-1:0] bad_pattern();
    logic [NUM_CAND-1:0] r;
    r = NUM_CAND'($urandom);
    if ($onehot(r)) r = '0;
    return r;
  endfunction

  // One voter session. bad < 0 picks random invalid patterns before the press.
  task automatic session(input logic [4:0] id, input bit st, input int ign,
                         input int cand, input bit abort, input int bad);
    bit  will_wait, accept, aborted;
    int  code_exp, last_k, db_hi, acc_edge, rej_edge, acc_n, rej_n, press_k;
    logic [NUM_CAND-1:0] bad_v;

    will_wait = st && !voted_m[id];
    aborted   = abort && will_wait;
    accept    = will_wait && !aborted;
    code_exp  = !st ? 1 : (!will_wait ? 2 : 0);
    press_k   = DB_LAT + 3 + ign;
    last_k    = press_k + 4;
    db_hi = 0; acc_edge = -1; rej_edge = -1; acc_n = 0; rej_n = 0;

    @(negedge clk);
    mode = 1'b1; voter_id = id; id_valid = 1'b1; db_status = st;
    bad_v = (bad < 0) ? bad_pattern() : NUM_CAND'(bad);
    cand_btn = bad_v;
    @(posedge clk); #1;
    check("start_db_read", db_read, 1);
    check("start_busy", busy, 1);
    check("start_code_cleared", reject_code, 0);
    if (db_read) db_hi++;

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      // A second ID during the lookup must be ignored.
      id_valid = (k == 1);
      voter_id = ~id;
      mode     = !(aborted && k == press_k);
      if (k >= press_k) cand_btn = NUM_CAND'(1) << cand;
      else              cand_btn = (bad < 0) ? bad_pattern() : bad_v;
      @(posedge clk); #1;
      if (k == 1) check("db_voter_id_latched", db_voter_id, id);
      if (db_read) db_hi++;
      if (vote_accepted) begin acc_n++; if (acc_edge < 0) acc_edge = k; end
      if (vote_rejected) begin rej_n++; if (rej_edge < 0) rej_edge = k; end
    end

    check("db_read_cycles", db_hi, DB_LAT + 1);
    check("accept_pulses", acc_n, accept ? 1 : 0);
    check("reject_pulses", rej_n, (code_exp != 0) ? 1 : 0);
    if (accept)        check("accept_latency", acc_edge, DB_LAT + 4 + ign);
    if (code_exp != 0) check("reject_latency", rej_edge, DB_LAT + 3);
    check("reject_code", reject_code, code_exp);
    check("end_idle", busy, 0);

    if (accept) begin
      voted_m[id] = 1'b1;
      if (count_m[cand] < CNT_MAX) count_m[cand]++;
      if (total_m < CNT_MAX) total_m++;
    end
    check("total_votes", total_votes, total_m);
    check("result_count_voting_mode", result_count, 0);
    @(negedge clk);
    cand_btn = '0;
    id_valid = 1'b0;
  endtask

  // Result readout in mode 0, including an ignored id_valid strobe.
  task automatic readout();
    @(negedge clk);
    mode = 1'b0; id_valid = 1'b1; voter_id = 5'd7;
    @(negedge clk);
    id_valid = 1'b0;
    check("readout_id_ignored", busy, 0);
    for (int c = 0; c < NUM_CAND; c++) begin
      result_sel = SEL_W'(c);
      #1;
      check($sformatf("result_count[%0d]", c), result_count, count_m[c]);
    end
    check("readout_total", total_votes, total_m);
    @(negedge clk);
    mode = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; id_valid = 1'b0; voter_id = '0;
    cand_btn = '0; result_sel = '0; db_status = 1'b0;
    model_clear();
    #12;
    check("reset_busy", busy, 0);
    check("reset_db_read", db_read, 0);
    check("reset_total", total_votes, 0);
    check("reset_code", reject_code, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed sessions
    session(5'b11011, 1'b1, 0, 1, 1'b0, 0);        // accepted, count[1]=1
    session(5'b11011, 1'b1, 0, 1, 1'b0, 0);        // already voted
    session(5'b00010, 1'b0, 0, 0, 1'b0, 0);        // not registered
    session(5'd9,     1'b1, 5, 2, 1'b0, 4'b0110);  // multi-hot ignored
    session(5'd12,    1'b1, 2, 3, 1'b1, 0);        // aborted in WAIT_VOTE
    readout();
    session(5'd12,    1'b1, 0, 0, 1'b0, 0);        // same voter after abort
    readout();

    // Randomized sessions
    for (int n = 0; n < 40; n++) begin
      session(5'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 4), $urandom_range(0, NUM_CAND - 1),
              ($urandom_range(0, 7) == 0), -1);
      if (n % 10 == 9) readout();
    end

    // Asynchronous reset in the middle of LOOKUP
    @(negedge clk);
    mode = 1'b1; voter_id = 5'd20; id_valid = 1'b1; db_status = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
    check("pre_reset_lookup", db_read, 1);
    #2; reset = 1'b1; #1;
    check("async_reset_db_read", db_read, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_db_voter_id", db_voter_id, 0);
    check("async_reset_total", total_votes, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    readout();
    session(5'b11011, 1'b1, 0, 2, 1'b0, 0);        // bitmap cleared by reset

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
